bus_decoder: RTL and testbench

// Address-decoding 1-to-N demux for the valid/resp memory bus; the counterpart of the N-to-1 arbiter.

---
 rtl/bus_decoder.sv | 186 ++++++++++++++++++
 tb/tb_bus_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bus_decoder.sv
// bus_decoder: address-decoding 1-to-N demux for the valid/resp memory bus.
// One requestor-side port is routed to the downstream port whose address
// window matches; its response and read data are returned. Unmapped addresses
// and targets that stay silent past TIMEOUT BUSY cycles get an error response.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   slave_addr_i/wdata_i/mask_i/we_i/valid_i    request from the requestor
//   slave_rdata_o/resp_o/err_o                  response to the requestor
//   master_addr_o/wdata_o/mask_o/we_o           broadcast to all ports
//   master_valid_o                              one-hot valid to selected port
//   master_rdata_i/resp_i                       per-port responses

// Window match for one downstream port.
module bus_decoder_port #(
  parameter int               ADDRW = 32,
  parameter logic [ADDRW-1:0] BASE  = '0,
  parameter logic [ADDRW-1:0] MASK  = '0
) (
  input  logic [ADDRW-1:0] addr_i,
  output logic             hit_o
);
  assign hit_o = ((addr_i & MASK) == BASE);
endmodule

module bus_decoder #(
  parameter int                      NPORTS     = 2,
  parameter int                      ADDRW      = 32,
  parameter int                      DATAW      = 32,
  parameter int                      MASKW      = DATAW / 8,
  parameter logic [NPORTS*ADDRW-1:0] BASE_ADDRS = {32'h1000_0000, 32'h0},
  parameter logic [NPORTS*ADDRW-1:0] ADDR_MASKS = {32'hF000_0000, 32'hF000_0000},
  parameter int                      TIMEOUT    = 255,
  parameter logic [DATAW-1:0]        ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDRW-1:0]          slave_addr_i,
  output logic [DATAW-1:0]          slave_rdata_o,
  input  logic [DATAW-1:0]          slave_wdata_i,
  input  logic [MASKW-1:0]          slave_mask_i,
  input  logic                      slave_we_i,
  input  logic                      slave_valid_i,
  output logic                      slave_resp_o,
  output logic                      slave_err_o,
  output logic [NPORTS*ADDRW-1:0]   master_addr_o,
  input  logic [NPORTS*DATAW-1:0]   master_rdata_i,
  output logic [NPORTS*DATAW-1:0]   master_wdata_o,
  output logic [NPORTS*MASKW-1:0]   master_mask_o,
  output logic [NPORTS-1:0]         master_we_o,
  output logic [NPORTS-1:0]         master_valid_o,
  input  logic [NPORTS-1:0]         master_resp_i
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  // TIMEOUT=0 disables the counter; keep it 1 bit wide so it still elaborates.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic [NPORTS-1:0] hit;
  logic              hit_any;
  logic [IW-1:0]     hit_idx;
  logic              hit_resp, sel_resp, tmo_hit;

  // Per-port window decode.
  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    bus_decoder_port #(
      .ADDRW(ADDRW),
      .BASE (BASE_ADDRS[g*ADDRW +: ADDRW]),
      .MASK (ADDR_MASKS[g*ADDRW +: ADDRW])
    ) u_port (
      .addr_i(slave_addr_i),
      .hit_o (hit[g])
    );
  end

  // Lowest index wins on overlapping windows: scan downward so the last
  // assignment is the lowest hitting port.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign hit_resp = master_resp_i[hit_idx];
  assign sel_resp = master_resp_i[sel_q];
  assign tmo_hit  = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

  // Request fields are broadcast; only master_valid_o is steered.
  assign master_addr_o  = {NPORTS{slave_addr_i}};
  assign master_wdata_o = {NPORTS{slave_wdata_i}};
  assign master_mask_o  = {NPORTS{slave_mask_i}};
  assign master_we_o    = {NPORTS{slave_we_i}};

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    // Saturating count so a long TIMEOUT=0 transaction never wraps.
    tmo_d   = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        tmo_d = tmo_q;
        if (slave_valid_i) begin
          if (!hit_any) begin
            state_d = S_ERR;
          end else if (!hit_resp) begin
            state_d = S_BUSY;
            sel_d   = hit_idx;
            tmo_d   = '0;
          end
        end
      end
      S_BUSY: begin
        // Dropped valid aborts silently; response beats a coincident timeout.
        if (!slave_valid_i || sel_resp || tmo_hit) state_d = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. Gated by rst_i so valid drops the moment reset asserts.
  always_comb begin
    master_valid_o = '0;
    slave_resp_o   = 1'b0;
    slave_err_o    = 1'b0;
    slave_rdata_o  = master_rdata_i[sel_q*DATAW +: DATAW];
    if (rst_i) begin
      slave_rdata_o = master_rdata_i[0 +: DATAW];
    end else begin
      case (state_q)
        S_IDLE: begin
          if (slave_valid_i && hit_any) begin
            master_valid_o[hit_idx] = 1'b1;
            slave_rdata_o           = master_rdata_i[hit_idx*DATAW +: DATAW];
            slave_resp_o            = hit_resp;
          end
        end
        S_BUSY: begin
          master_valid_o[sel_q] = slave_valid_i;
          if (slave_valid_i) begin
            if (sel_resp) begin
              slave_resp_o = 1'b1;
            end else if (tmo_hit) begin
              slave_resp_o  = 1'b1;
              slave_err_o   = 1'b1;
              slave_rdata_o = ERR_DATA;
            end
          end
        end
        S_ERR: begin
          slave_resp_o  = 1'b1;
          slave_err_o   = 1'b1;
          slave_rdata_o = ERR_DATA;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_decoder.sv
module tb_bus_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_addr = '0, s_wdata = '0, s_rdata;
  logic [3:0]  s_mask = '0;
  logic        s_we = 1'b0, s_valid = 1'b0, s_resp, s_err;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [31:0] rd0 = 32'h1111_0000, rd1 = 32'hCAFE_0001;
  logic [7:0]  m_mask;
  logic [1:0]  m_we, m_valid, m_resp = '0;

  int checks = 0, errors = 0;

  assign m_rdata = {rd1, rd0};

  always #5 clk = ~clk;

  bus_decoder #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .slave_addr_i(s_addr), .slave_rdata_o(s_rdata), .slave_wdata_i(s_wdata),
    .slave_mask_i(s_mask), .slave_we_i(s_we), .slave_valid_i(s_valid),
    .slave_resp_o(s_resp), .slave_err_o(s_err),
    .master_addr_o(m_addr), .master_rdata_i(m_rdata), .master_wdata_o(m_wdata),
    .master_mask_o(m_mask), .master_we_o(m_we), .master_valid_o(m_valid),
    .master_resp_i(m_resp)
  );

  typedef struct {
    logic        v;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  mk;
    logic [1:0]  rsp;
    logic [31:0] r0, r1;
    logic [1:0]  e_mv;
    logic        e_rsp, e_err, chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of request inputs just after the edge, then wait to sample.
  task automatic apply(input logic v, input logic [31:0] a, input logic [1:0] r);
    @(posedge clk); #1;
    s_valid = v; s_addr = a; m_resp = r; s_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic outs(input string nm, input logic [1:0] mv, input logic rs, input logic er);
    chk({nm, ".mvalid"}, 64'(m_valid), 64'(mv));
    chk({nm, ".resp"},   64'(s_resp),  64'(rs));
    chk({nm, ".err"},    64'(s_err),   64'(er));
  endtask

  initial begin
    // Sequential trace; state carries from row to row.
    // read 0x1000_0004, port 1 responds on the 4th cycle
    tbl[0]  = '{1'b1, 32'h1000_0004, 1'b0, 32'h0, 4'h0, 2'b00, 32'h1111_0000, 32'hCAFE_0001, 2'b10, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001};
    tbl[1]  = '{1'b1, 32'h1000_0004, 1'b0, 32'h0, 4'h0, 2'b00, 32'h1111_0000, 32'hCAFE_0001, 2'b10, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001};
    tbl[2]  = '{1'b1, 32'h1000_0004, 1'b0, 32'h0, 4'h0, 2'b00, 32'h1111_0000, 32'hCAFE_0001, 2'b10, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001};
    tbl[3]  = '{1'b1, 32'h1000_0004, 1'b0, 32'h0, 4'h0, 2'b10, 32'h1111_0000, 32'hCAFE_0001, 2'b10, 1'b1, 1'b0, 1'b1, 32'hCAFE_0001};
    // port 0 zero-latency write, then back-to-back request
    tbl[4]  = '{1'b1, 32'h0000_0010, 1'b1, 32'h55, 4'h1, 2'b01, 32'h1111_0000, 32'hCAFE_0001, 2'b01, 1'b1, 1'b0, 1'b1, 32'h1111_0000};
    tbl[5]  = '{1'b1, 32'h0000_0020, 1'b0, 32'h0, 4'hF, 2'b01, 32'h1111_0000, 32'hCAFE_0001, 2'b01, 1'b1, 1'b0, 1'b1, 32'h1111_0000};
    // unmapped: nothing downstream, err one cycle later
    tbl[6]  = '{1'b1, 32'h2000_0000, 1'b0, 32'h0, 4'h0, 2'b00, 32'h1111_0000, 32'hCAFE_0001, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 32'h2000_0000, 1'b0, 32'h0, 4'h0, 2'b00, 32'h1111_0000, 32'hCAFE_0001, 2'b00, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF};
    // stray responses while idle are ignored
    tbl[8]  = '{1'b0, 32'h2000_0000, 1'b0, 32'h0, 4'h0, 2'b11, 32'h1111_0000, 32'hCAFE_0001, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
    // port 1 busy, port 0 spurious resp
    tbl[9]  = '{1'b1, 32'h1000_0000, 1'b0, 32'h0, 4'h0, 2'b01, 32'h1111_0000, 32'h1234_5678, 2'b10, 1'b0, 1'b0, 1'b1, 32'h1234_5678};
    tbl[10] = '{1'b1, 32'h1000_0000, 1'b0, 32'h0, 4'h0, 2'b01, 32'h1111_0000, 32'h1234_5678, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 32'h1000_0000, 1'b0, 32'h0, 4'h0, 2'b11, 32'h1111_0000, 32'h1234_5678, 2'b10, 1'b1, 1'b0, 1'b1, 32'h1234_5678};
    tbl[12] = '{1'b0, 32'h1000_0000, 1'b0, 32'h0, 4'h0, 2'b00, 32'h1111_0000, 32'h1234_5678, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};

    // Reset state: a port-1 request held during reset must not leak out.
    s_valid = 1'b1; s_addr = 32'h1000_0000;
    @(negedge clk);
    outs("reset", 2'b00, 1'b0, 1'b0);
    chk("reset.rdata", 64'(s_rdata), 64'(32'h1111_0000));
    @(posedge clk); #1 s_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      s_valid = tbl[i].v; s_addr = tbl[i].addr; s_we = tbl[i].we;
      s_wdata = tbl[i].wd; s_mask = tbl[i].mk; m_resp = tbl[i].rsp;
      rd0 = tbl[i].r0; rd1 = tbl[i].r1;
      @(negedge clk);
      outs($sformatf("vec%0d", i), tbl[i].e_mv, tbl[i].e_rsp, tbl[i].e_err);
      if (tbl[i].chk_rd) chk($sformatf("vec%0d.rdata", i), 64'(s_rdata), 64'(tbl[i].e_rd));
      if (tbl[i].v) begin
        chk($sformatf("vec%0d.addr", i), m_addr, {2{tbl[i].addr}});
        chk($sformatf("vec%0d.wdata", i), m_wdata, {2{tbl[i].wd}});
        chk($sformatf("vec%0d.mask", i), 64'(m_mask), 64'({2{tbl[i].mk}}));
        chk($sformatf("vec%0d.we", i), 64'(m_we), 64'({2{tbl[i].we}}));
      end
    end

    rd0 = 32'h0A0A_0000; rd1 = 32'h0B0B_0001;

    // Timeout: 1 IDLE cycle, then err on the 4th BUSY cycle.
    apply(1'b1, 32'h0000_0100, 2'b00);
    outs("tmo.idle", 2'b01, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 32'h0000_0100, 2'b00);
      outs($sformatf("tmo.busy%0d", k), 2'b01, k == 3, k == 3);
    end
    chk("tmo.rdata", 64'(s_rdata), 64'(32'hDEAD_BEEF));
    apply(1'b0, 32'h0000_0100, 2'b01);
    outs("tmo.late", 2'b00, 1'b0, 1'b0);

    // Response coincides with the timeout cycle: response wins.
    apply(1'b1, 32'h0000_0100, 2'b00);
    for (int k = 0; k < 3; k++) apply(1'b1, 32'h0000_0100, 2'b00);
    apply(1'b1, 32'h0000_0100, 2'b01);
    outs("tmo.race", 2'b01, 1'b1, 1'b0);
    chk("tmo.race.rdata", 64'(s_rdata), 64'(32'h0A0A_0000));
    apply(1'b0, 32'h0000_0100, 2'b00);

    // Valid dropped mid-BUSY: silent abort, later resp ignored.
    apply(1'b1, 32'h1000_0000, 2'b00);
    apply(1'b1, 32'h1000_0000, 2'b00);
    apply(1'b0, 32'h1000_0000, 2'b00);
    outs("abort", 2'b00, 1'b0, 1'b0);
    apply(1'b0, 32'h1000_0000, 2'b10);
    outs("abort.late", 2'b00, 1'b0, 1'b0);
    apply(1'b1, 32'h1000_0000, 2'b10);
    outs("abort.next", 2'b10, 1'b1, 1'b0);
    chk("abort.next.rdata", 64'(s_rdata), 64'(32'h0B0B_0001));

    // Reset mid-BUSY: valid drops without waiting for an edge.
    apply(1'b1, 32'h1000_0000, 2'b00);
    apply(1'b1, 32'h1000_0000, 2'b00);
    outs("rstb.busy", 2'b10, 1'b0, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    outs("rstb.async", 2'b00, 1'b0, 1'b0);
    chk("rstb.rdata", 64'(s_rdata), 64'(32'h0A0A_0000));
    @(posedge clk); #1 rst = 1'b0; s_valid = 1'b0;
    apply(1'b1, 32'h0000_0040, 2'b01);
    outs("rstb.after", 2'b01, 1'b1, 1'b0);
    chk("rstb.after.rdata", 64'(s_rdata), 64'(32'h0A0A_0000));
    apply(1'b0, 32'h0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
